// File: rtl/hc595_row_sequencer.sv
// Row scanner feeding a 74HC595 byte loader: buffers one frame, loads each row byte,
// latches it with STCP and lights the row for a fixed dwell before moving on.
module hc595_row_sequencer #(
  parameter int ROWS         = 8,
  parameter int LATCH_CYCLES = 2,
  parameter int DWELL        = 1000,
  parameter int TIMEOUT      = 256,
  localparam int ROW_W       = $clog2(ROWS)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             wr_en_i,
  input  logic [ROW_W-1:0] wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic             err_clr_i,
  output logic [7:0]       load_data_o,
  output logic             load_start_o,
  input  logic             load_finish_i,
  output logic             STCP_o,
  output logic             OE_n_o,
  output logic [ROW_W-1:0] row_sel_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             err_o
);

  // One shared counter serves SHIFT timeout, LATCH width and DWELL time.
  localparam int CNT_MAX = (TIMEOUT > DWELL) ?
                           ((TIMEOUT > LATCH_CYCLES) ? TIMEOUT : LATCH_CYCLES) :
                           ((DWELL > LATCH_CYCLES) ? DWELL : LATCH_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam bit               DWELL_ONE  = (DWELL == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    LATCH,
    DWELL_ST
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       frame_q [ROWS];
  logic [7:0]       load_data_q, load_data_d;
  logic             load_start_q, load_start_d;
  logic             stcp_q, stcp_d;
  logic             oe_n_q, oe_n_d;
  logic [ROW_W-1:0] row_sel_q, row_sel_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q;
  logic             err_q, err_d;
  logic [ROW_W-1:0] row_next;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_start_d = 1'b0;
    stcp_d       = stcp_q;
    oe_n_d       = oe_n_q;
    row_sel_d    = row_sel_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    row_next     = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;

    // Clear is evaluated first so a same-cycle timeout overrides it.
    if (err_clr_i) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        oe_n_d = 1'b1;
        if (enable_i) begin
          state_d      = START;
          load_start_d = 1'b1;
          load_data_d  = frame_q[row_q];
          cnt_d        = '0;
        end
      end
      START: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        if ((cnt_q != '0) && load_finish_i) begin
          state_d   = LATCH;
          stcp_d    = 1'b1;
          oe_n_d    = 1'b1;
          row_sel_d = row_q;
          cnt_d     = '0;
        end else if (cnt_q == TO_LAST) begin
          err_d        = 1'b1;
          state_d      = START;
          load_start_d = 1'b1;
          load_data_d  = frame_q[row_q];
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d      = DWELL_ST;
          stcp_d       = 1'b0;
          oe_n_d       = 1'b0;
          cnt_d        = '0;
          frame_done_d = DWELL_ONE && (row_q == ROW_LAST);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DWELL_ST: begin
        if (cnt_q == DWELL_LAST) begin
          row_d = row_next;
          cnt_d = '0;
          if (enable_i) begin
            state_d      = START;
            load_start_d = 1'b1;
            load_data_d  = frame_q[row_next];
          end else begin
            state_d = IDLE;
            oe_n_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          // frame_done is registered, so it is raised going into the final dwell cycle.
          frame_done_d = ((cnt_q + CNT_ONE) == DWELL_LAST) && (row_q == ROW_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_start_q <= 1'b0;
      stcp_q       <= 1'b0;
      oe_n_q       <= 1'b1;
      row_sel_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_start_q <= load_start_d;
      stcp_q       <= stcp_d;
      oe_n_q       <= oe_n_d;
      row_sel_q    <= row_sel_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != IDLE);
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < ROWS; i++) frame_q[i] <= '0;
    end else if (wr_en_i && (int'(wr_addr_i) < ROWS)) begin
      frame_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign load_data_o  = load_data_q;
  assign load_start_o = load_start_q;
  assign STCP_o       = stcp_q;
  assign OE_n_o       = oe_n_q;
  assign row_sel_o    = row_sel_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_hc595_row_sequencer.sv
// Self-checking bench for hc595_row_sequencer: a loader model answers START pulses and a
// scoreboard of expected (row, byte) pairs is consumed on every START the DUT issues.
module tb_hc595_row_sequencer;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       enable = 1'b0;
  logic       wrEn = 1'b0;
  logic [2:0] wrAddr = '0;
  logic [7:0] wrData = '0;
  logic       errClr = 1'b0;
  logic       loadFinish = 1'b0;
  logic [7:0] load_data_o;
  logic       load_start_o;
  logic       STCP_o;
  logic       OE_n_o;
  logic [2:0] row_sel_o;
  logic       frame_done_o;
  logic       busy_o;
  logic       err_o;

  hc595_row_sequencer #(
    .ROWS(8), .LATCH_CYCLES(2), .DWELL(20), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .reset_ni(resetN), .enable_i(enable), .wr_en_i(wrEn),
    .wr_addr_i(wrAddr), .wr_data_i(wrData), .err_clr_i(errClr),
    .load_data_o(load_data_o), .load_start_o(load_start_o), .load_finish_i(loadFinish),
    .STCP_o(STCP_o), .OE_n_o(OE_n_o), .row_sel_o(row_sel_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] row;
  } expT;

  expT        expQ[$];
  logic [7:0] mirror [8];
  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int sinceStart = 0;
  int lastGap = 0;
  int stcpHigh = 0;
  int frameDoneCount = 0;
  int expLatchDelay = 11;
  int loaderMode = 0;
  int finCount = 0;
  logic [2:0] curRow = '0;
  bit   monOn = 1'b0;
  bit   prevStcp = 1'b0;

  // Loader model: mode 0 finishes 10 cycles after START, 1 holds finish high, 2 never finishes.
  always @(negedge clk) begin
    if (loaderMode == 1) begin
      loadFinish = 1'b1;
      finCount = 0;
    end else if (loaderMode == 2) begin
      loadFinish = 1'b0;
      finCount = 0;
    end else if (load_start_o) begin
      loadFinish = 1'b0;
      finCount = 10;
    end else if (finCount > 0) begin
      finCount--;
      if (finCount == 0) loadFinish = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (monOn) begin
      if (load_start_o) begin
        lastGap = sinceStart + 1;
        sinceStart = 0;
        startCount++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL start_unexpected: got START with load_data %h, required none", load_data_o);
        end else begin
          expT e;
          e = expQ.pop_front();
          curRow = e.row;
          if (load_data_o !== e.data) begin
            errors++;
            $display("[TB] FAIL load_data row %0d: got %h, required %h", e.row, load_data_o, e.data);
          end
        end
      end else begin
        sinceStart++;
      end
      if (STCP_o && !prevStcp) begin
        checks++;
        if ({row_sel_o, OE_n_o} !== {curRow, 1'b1} || sinceStart != expLatchDelay) begin
          errors++;
          $display("[TB] FAIL latch_entry: row_sel %0d OE_n %b delay %0d, required row_sel %0d OE_n 1 delay %0d",
                   row_sel_o, OE_n_o, sinceStart, curRow, expLatchDelay);
        end
      end
      if (STCP_o) begin
        stcpHigh++;
      end else if (prevStcp) begin
        checks++;
        if (stcpHigh != 2) begin
          errors++;
          $display("[TB] FAIL stcp_width: got %0d cycles, required 2", stcpHigh);
        end
        stcpHigh = 0;
      end
      if (frame_done_o) begin
        frameDoneCount++;
        checks++;
        if (row_sel_o !== 3'd7 || OE_n_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL frame_done_ctx: row_sel %0d OE_n %b, required row_sel 7 OE_n 0", row_sel_o, OE_n_o);
        end
      end
      prevStcp = STCP_o;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic writeRow(input logic [2:0] addr, input logic [7:0] data);
    wrEn = 1'b1;
    wrAddr = addr;
    wrData = data;
    step();
    wrEn = 1'b0;
    mirror[addr] = data;
  endtask

  task automatic pushRows(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      expT e;
      r = (first + i) % 8;
      e.row = 3'(r);
      e.data = mirror[r];
      expQ.push_back(e);
    end
  endtask

  task automatic waitStarts(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (startCount >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok;
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
    for (int i = 0; i < 8; i++) writeRow(3'(i), 8'h55);
    resetN = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) mirror[i] = 8'h00;
    step();
    step();
    step();
    checks++;
    if ({load_data_o, load_start_o, STCP_o, OE_n_o, row_sel_o, frame_done_o, busy_o, err_o}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: data %h start %b stcp %b oe_n %b row %0d fd %b busy %b err %b, required 00 0 0 1 0 0 0 0",
               load_data_o, load_start_o, STCP_o, OE_n_o, row_sel_o, frame_done_o, busy_o, err_o);
    end
    pushRows(0, 8);
    monOn = 1'b1;
    resetN = 1'b1;
    waitStarts(8, ok);
    enable = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL reset_frame_starts: got %0d starts, required 8", startCount);
    end
    waitIdle(ok);
    checks++;
    if (!ok || frameDoneCount != 1 || OE_n_o !== 1'b1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_frame_end: idle %b frame_done %0d OE_n %b pending %0d, required 1 1 1 0",
               ok, frameDoneCount, OE_n_o, expQ.size());
    end
  endtask

  task automatic test_scan();
    bit ok;
    int base;
    int fdBase;
    logic [7:0] pattern [8];
    pattern = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h81, 8'h42, 8'h24, 8'h18};
    for (int i = 0; i < 8; i++) writeRow(3'(i), pattern[i]);
    base = startCount;
    fdBase = frameDoneCount;
    pushRows(0, 16);
    enable = 1'b1;
    waitStarts(base + 16, ok);
    enable = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL scan_starts: got %0d starts, required %0d", startCount - base, 16);
    end
    waitIdle(ok);
    checks++;
    if (!ok || frameDoneCount - fdBase != 2 || row_sel_o !== 3'd7 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scan_end: idle %b frame_done %0d row_sel %0d pending %0d, required 1 2 7 0",
               ok, frameDoneCount - fdBase, row_sel_o, expQ.size());
    end
  endtask

  task automatic test_stale_finish();
    bit ok;
    int base;
    loaderMode = 1;
    step();
    step();
    base = startCount;
    expLatchDelay = 3;
    pushRows(0, 2);
    enable = 1'b1;
    waitStarts(base + 2, ok);
    enable = 1'b0;
    waitIdle(ok);
    checks++;
    if (!ok || row_sel_o !== 3'd1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL stale_end: idle %b row_sel %0d pending %0d, required 1 1 0", ok, row_sel_o, expQ.size());
    end
    loaderMode = 0;
    expLatchDelay = 11;
  endtask

  task automatic test_timeout();
    bit ok;
    int base;
    loaderMode = 2;
    step();
    base = startCount;
    pushRows(2, 1);
    pushRows(2, 1);
    pushRows(2, 1);
    enable = 1'b1;
    waitStarts(base + 1, ok);
    enable = 1'b0;
    checks++;
    if (!ok || err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pre: started %b err %b, required 1 0", ok, err_o);
    end
    waitStarts(base + 2, ok);
    checks++;
    if (!ok || lastGap != 17 || err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_retry: started %b gap %0d err %b, required 1 17 1", ok, lastGap, err_o);
    end
    errClr = 1'b1;
    loaderMode = 0;
    step();
    step();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got %b, required 0", err_o);
    end
    waitStarts(base + 3, ok);
    checks++;
    if (!ok || lastGap != 17 || err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_set_wins: started %b gap %0d err %b, required 1 17 1", ok, lastGap, err_o);
    end
    step();
    errClr = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear_after: got %b, required 0", err_o);
    end
    waitIdle(ok);
    checks++;
    if (!ok || row_sel_o !== 3'd2 || err_o !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL timeout_end: idle %b row_sel %0d err %b pending %0d, required 1 2 0 0",
               ok, row_sel_o, err_o, expQ.size());
    end
  endtask

  task automatic test_write_in_shift();
    bit ok;
    int base;
    int fdBase;
    logic [7:0] oldByte;
    expT e;
    base = startCount;
    fdBase = frameDoneCount;
    oldByte = mirror[3];
    pushRows(3, 8);
    e.row = 3'd3;
    e.data = 8'hFF;
    expQ.push_back(e);
    enable = 1'b1;
    waitStarts(base + 1, ok);
    step();
    writeRow(3'd3, 8'hFF);
    step();
    checks++;
    if (load_data_o !== oldByte) begin
      errors++;
      $display("[TB] FAIL load_data_hold: got %h, required %h", load_data_o, oldByte);
    end
    waitStarts(base + 9, ok);
    enable = 1'b0;
    waitIdle(ok);
    checks++;
    if (!ok || frameDoneCount - fdBase != 1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL write_shift_end: idle %b frame_done %0d pending %0d, required 1 1 0",
               ok, frameDoneCount - fdBase, expQ.size());
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int base;
    base = startCount;
    pushRows(4, 2);
    enable = 1'b1;
    waitStarts(base + 2, ok);
    for (int i = 0; i < 100 && !STCP_o; i++) step();
    enable = 1'b0;
    waitIdle(ok);
    checks++;
    if (!ok || OE_n_o !== 1'b1 || row_sel_o !== 3'd5 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL enable_drop_end: idle %b OE_n %b row_sel %0d pending %0d, required 1 1 5 0",
               ok, OE_n_o, row_sel_o, expQ.size());
    end
    // The write lands on the same edge that enters START, so row 6 must still load its old byte.
    pushRows(6, 1);
    enable = 1'b1;
    writeRow(3'd6, 8'h5A);
    waitStarts(base + 3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL reenable_start: got %0d starts, required %0d", startCount - base, 3);
    end
    step();
    step();
    monOn = 1'b0;
    resetN = 1'b0;
    #1;
    checks++;
    if ({load_data_o, load_start_o, STCP_o, OE_n_o, row_sel_o, frame_done_o, busy_o, err_o}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midop_reset: data %h start %b stcp %b oe_n %b row %0d fd %b busy %b err %b, required 00 0 0 1 0 0 0 0",
               load_data_o, load_start_o, STCP_o, OE_n_o, row_sel_o, frame_done_o, busy_o, err_o);
    end
    enable = 1'b0;
    step();
    resetN = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mirror[i] = 8'h00;
    test_reset();
    test_scan();
    test_stale_finish();
    test_timeout();
    test_write_in_shift();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
